// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: issues MULT/MULTU/DIV/DIVU/MTHI/MTLO,
// runs a fixed-latency countdown for mul/div and owns the HI/LO registers.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        req,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] pending_hi, pending_lo, pend_hi_nxt, pend_lo_nxt;
   logic        pend_wr, pend_wr_nxt;
   logic [31:0] hi_nxt, lo_nxt;
   logic        issue;
   logic [63:0] mul_res, div_res;

   // 64-bit product; operands are sign- or zero-extended so one multiplier serves both
   function automatic logic [63:0] mul_result(input logic is_signed,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb, prod;
      sa   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      sb   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
      prod = sa * sb;
      return prod;
   endfunction

   // Returns {remainder, quotient}. Signed case works on magnitudes so that
   // 0x80000000 / -1 wraps to 0x80000000 without overflow.
   function automatic logic [63:0] div_result(input logic is_signed,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic        neg_a, neg_b;
      logic [31:0] ma, mb, q, r;
      neg_a = is_signed & a[31];
      neg_b = is_signed & b[31];
      ma    = neg_a ? -a : a;
      mb    = neg_b ? -b : b;
      if (mb == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (neg_a ^ neg_b) q = -q;
      if (neg_a)         r = -r;
      return {r, q};
   endfunction

   assign mul_res = mul_result(md_op == OP_MULT, rs_val, rt_val);
   assign div_res = div_result(md_op == OP_DIV,  rs_val, rt_val);
   assign issue   = start && !req && (state == IDLE) &&
                    (md_op >= OP_MULT) && (md_op <= OP_MTLO);
   assign busy    = (state == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
         pend_wr    <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pending_hi <= pend_hi_nxt;
         pending_lo <= pend_lo_nxt;
         pend_wr    <= pend_wr_nxt;
         hi         <= hi_nxt;
         lo         <= lo_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_hi_nxt = pending_hi;
      pend_lo_nxt = pending_lo;
      pend_wr_nxt = pend_wr;
      hi_nxt      = hi;
      lo_nxt      = lo;
      case (state)
         IDLE: begin
            if (issue) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     {pend_hi_nxt, pend_lo_nxt} = mul_res;
                     pend_wr_nxt = 1'b1;
                     cnt_nxt     = MULT_CNT;
                     state_nxt   = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero still burns the full latency but commits nothing
                     {pend_hi_nxt, pend_lo_nxt} = div_res;
                     pend_wr_nxt = (rt_val != 32'd0);
                     cnt_nxt     = DIV_CNT;
                     state_nxt   = RUN;
                  end
                  OP_MTHI: hi_nxt = rs_val;
                  OP_MTLO: lo_nxt = rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nxt = IDLE;
               if (pend_wr) begin
                  hi_nxt = pending_hi;
                  lo_nxt = pending_lo;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic results, busy window, gating and reset.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic        req;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_pass = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .req    (req),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      cyc();
      start  = 1'b0;
      md_op  = 3'd0;
   endtask

   // Issue, expect busy for exactly n cycles, then check HI/LO
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(op, a, b);
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, {31'd0, busy}, 32'd1);
         cyc();
      end
      chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      int busy_cnt;
      reset  = 1'b1;
      start  = 1'b0;
      md_op  = 3'd0;
      req    = 1'b0;
      rs_val = 32'd0;
      rt_val = 32'd0;
      #2;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      cyc();
      reset = 1'b0;
      cyc();

      run_op("mult",  3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      // MTHI in the first cycle after completion overwrites the fresh HI
      issue(3'd5, 32'h0000_BEEF, 32'd0);
      chk("b2b mthi busy", {31'd0, busy}, 32'd0);
      chk("b2b mthi hi", hi, 32'h0000_BEEF);
      chk("b2b mthi lo", lo, 32'hFFFF_FFF1);

      run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",  3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_op("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      issue(3'd5, 32'h0000_1234, 32'd0);
      issue(3'd6, 32'h0000_5678, 32'd0);
      chk("mt busy", {31'd0, busy}, 32'd0);
      chk("mthi", hi, 32'h0000_1234);
      chk("mtlo", lo, 32'h0000_5678);
      run_op("div0", 3'd3, 32'd9, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

      // Issue blocked by req
      req = 1'b1;
      issue(3'd1, 32'd3, 32'd4);
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("req busy", {31'd0, busy}, 32'd0);
         cyc();
      end
      chk("req hi", hi, 32'h0000_1234);
      chk("req lo", lo, 32'h0000_5678);

      // MTLO during an active DIV is dropped; DIV result still lands
      issue(3'd3, 32'd100, 32'd7);
      busy_cnt = 0;
      if (busy) busy_cnt++;
      cyc();
      if (busy) busy_cnt++;
      issue(3'd6, 32'h0000_AAAA, 32'd0);
      chk("drop mtlo lo", lo, 32'h0000_5678);
      for (int i = 0; i < 20 && busy; i++) begin
         busy_cnt++;
         cyc();
      end
      chk("drop busy end", {31'd0, busy}, 32'd0);
      chk("drop busy cycles", 32'(busy_cnt), 32'd10);
      chk("drop hi", hi, 32'd2);
      chk("drop lo", lo, 32'd14);

      // Reset in busy cycle 3 of a MULT clears outputs before the next edge
      issue(3'd1, 32'd7, 32'd6);
      cyc();
      cyc();
      chk("rst pre busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst async busy", {31'd0, busy}, 32'd0);
      chk("rst async hi", hi, 32'd0);
      chk("rst async lo", lo, 32'd0);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("rst after busy", {31'd0, busy}, 32'd0);
         cyc();
      end
      chk("rst after hi", hi, 32'd0);
      chk("rst after lo", lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
